tlb_ptw_requestor: RTL and testbench

Requestor-side client of the page-table-walker request/response port. It sits between one TLB, such as the I-TLB or the D-TLB, and one PTW requestor slot (slot 0 or slot 1). It accepts a TLB miss, holds a single walk request until the PTW arbiter takes it, and waits for the PTE response. It then returns a one-cycle refill carrying the PTE and a permission-fault flag, and supports flushing a walk that is in flight.

---
 rtl/tlb_ptw_requestor_if.sv | 69 ++++++
 rtl/tlb_ptw_requestor.sv | 145 ++++++++++++++
 tb/tb_tlb_ptw_requestor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ptw_requestor_if.sv
// TLB-miss / PTW request-response / refill bundle for one requestor slot.
interface tlb_ptw_requestor_if #(
  parameter int CNT_W = 16
) ();
  logic             miss_valid;
  logic             miss_ready;
  logic [26:0]      miss_addr;
  logic [1:0]       miss_prv;
  logic             miss_pum;
  logic             miss_mxr;
  logic             miss_store;
  logic             miss_fetch;
  logic             flush;

  logic             io_ptw_req_valid;
  logic             io_ptw_req_ready;
  logic [1:0]       io_ptw_req_bits_prv;
  logic             io_ptw_req_bits_pum;
  logic             io_ptw_req_bits_mxr;
  logic             io_ptw_req_bits_store;
  logic             io_ptw_req_bits_fetch;
  logic [26:0]      io_ptw_req_bits_addr;

  logic             io_ptw_resp_valid;
  logic [37:0]      io_ptw_resp_bits_pte_ppn;
  logic [15:0]      io_ptw_resp_bits_pte_reserved_for_hardware;
  logic [1:0]       io_ptw_resp_bits_pte_reserved_for_software;
  logic             io_ptw_resp_bits_pte_d;
  logic             io_ptw_resp_bits_pte_a;
  logic             io_ptw_resp_bits_pte_g;
  logic             io_ptw_resp_bits_pte_u;
  logic             io_ptw_resp_bits_pte_x;
  logic             io_ptw_resp_bits_pte_w;
  logic             io_ptw_resp_bits_pte_r;
  logic             io_ptw_resp_bits_pte_v;

  logic             refill_valid;
  logic [26:0]      refill_addr;
  logic [37:0]      refill_ppn;
  logic [7:0]       refill_flags;
  logic             refill_fault;
  logic [CNT_W-1:0] walk_count;

  // TLB / arbiter side: drives misses, flush, ready and responses.
  modport master (
    output miss_valid, miss_addr, miss_prv, miss_pum, miss_mxr, miss_store, miss_fetch, flush,
    output io_ptw_req_ready,
    output io_ptw_resp_valid, io_ptw_resp_bits_pte_ppn,
    output io_ptw_resp_bits_pte_reserved_for_hardware, io_ptw_resp_bits_pte_reserved_for_software,
    output io_ptw_resp_bits_pte_d, io_ptw_resp_bits_pte_a, io_ptw_resp_bits_pte_g, io_ptw_resp_bits_pte_u,
    output io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_r, io_ptw_resp_bits_pte_v,
    input  miss_ready, io_ptw_req_valid, io_ptw_req_bits_prv, io_ptw_req_bits_pum, io_ptw_req_bits_mxr,
    input  io_ptw_req_bits_store, io_ptw_req_bits_fetch, io_ptw_req_bits_addr,
    input  refill_valid, refill_addr, refill_ppn, refill_flags, refill_fault, walk_count
  );

  // Requestor side: the walk-request client itself.
  modport slave (
    input  miss_valid, miss_addr, miss_prv, miss_pum, miss_mxr, miss_store, miss_fetch, flush,
    input  io_ptw_req_ready,
    input  io_ptw_resp_valid, io_ptw_resp_bits_pte_ppn,
    input  io_ptw_resp_bits_pte_reserved_for_hardware, io_ptw_resp_bits_pte_reserved_for_software,
    input  io_ptw_resp_bits_pte_d, io_ptw_resp_bits_pte_a, io_ptw_resp_bits_pte_g, io_ptw_resp_bits_pte_u,
    input  io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_r, io_ptw_resp_bits_pte_v,
    output miss_ready, io_ptw_req_valid, io_ptw_req_bits_prv, io_ptw_req_bits_pum, io_ptw_req_bits_mxr,
    output io_ptw_req_bits_store, io_ptw_req_bits_fetch, io_ptw_req_bits_addr,
    output refill_valid, refill_addr, refill_ppn, refill_flags, refill_fault, walk_count
  );
endinterface

// File: rtl/tlb_ptw_requestor.sv
// Single-outstanding PTW requestor: latches a TLB miss, issues the walk,
// waits for the PTE and returns a one-cycle refill with a permission fault.
module tlb_ptw_requestor #(
  parameter int CNT_W = 16
) (
  input logic                 clock,
  input logic                 reset,
  tlb_ptw_requestor_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_REFILL = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [26:0]      addr_q;
  logic [1:0]       prv_q;
  logic             pum_q, mxr_q, store_q, fetch_q;
  logic [26:0]      refill_addr_q;
  logic [37:0]      ppn_q;
  logic [7:0]       flags_q;
  logic             fault_q;
  logic [CNT_W-1:0] count_q;

  logic [7:0]       pte_flags_s;
  logic             accept_s;
  logic             commit_s;
  logic             unused_pte_bits;

  // Permission check; flags are {d,a,g,u,x,w,r,v}. M-mode ignores the u bit.
  function automatic logic pte_fault(input logic [1:0] prv, input logic pum, input logic mxr,
                                     input logic store, input logic fetch, input logic [7:0] fl);
    logic v, r, w, x, u, d;
    v = fl[0]; r = fl[1]; w = fl[2]; x = fl[3]; u = fl[4]; d = fl[7];
    return (!v)
         | (fetch & !x)
         | (store & !(w & d))
         | (!fetch & !store & !(r | (mxr & x)))
         | ((prv == 2'd0) & !u)
         | ((prv == 2'd1) & u & (pum | fetch));
  endfunction

  assign pte_flags_s = {bus.io_ptw_resp_bits_pte_d, bus.io_ptw_resp_bits_pte_a,
                        bus.io_ptw_resp_bits_pte_g, bus.io_ptw_resp_bits_pte_u,
                        bus.io_ptw_resp_bits_pte_x, bus.io_ptw_resp_bits_pte_w,
                        bus.io_ptw_resp_bits_pte_r, bus.io_ptw_resp_bits_pte_v};
  assign accept_s = (state_q == S_IDLE) & bus.miss_valid;
  // A response that coincides with flush is discarded, never committed.
  assign commit_s = (state_q == S_WAIT) & bus.io_ptw_resp_valid & !bus.flush;
  assign unused_pte_bits = ^{bus.io_ptw_resp_bits_pte_reserved_for_hardware,
                             bus.io_ptw_resp_bits_pte_reserved_for_software};

  // Next-state logic, including flush handling per state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) state_d = S_REQ;
        else                state_d = S_IDLE;
      end
      S_REQ: begin
        if (bus.flush)                 state_d = bus.io_ptw_req_ready ? S_DRAIN : S_IDLE;
        else if (bus.io_ptw_req_ready) state_d = S_WAIT;
        else                           state_d = S_REQ;
      end
      S_WAIT: begin
        if (bus.io_ptw_resp_valid) state_d = bus.flush ? S_IDLE : S_REFILL;
        else if (bus.flush)        state_d = S_DRAIN;
        else                       state_d = S_WAIT;
      end
      S_REFILL: state_d = S_IDLE;
      S_DRAIN: begin
        if (bus.io_ptw_resp_valid) state_d = S_IDLE;
        else                       state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch the request attributes when a miss is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= 27'd0;
      prv_q   <= 2'd0;
      pum_q   <= 1'b0;
      mxr_q   <= 1'b0;
      store_q <= 1'b0;
      fetch_q <= 1'b0;
    end else if (accept_s) begin
      addr_q  <= bus.miss_addr;
      prv_q   <= bus.miss_prv;
      pum_q   <= bus.miss_pum;
      mxr_q   <= bus.miss_mxr;
      store_q <= bus.miss_store;
      fetch_q <= bus.miss_fetch;
    end
  end

  // Capture the PTE and its fault verdict; held until the next committed response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refill_addr_q <= 27'd0;
      ppn_q         <= 38'd0;
      flags_q       <= 8'd0;
      fault_q       <= 1'b0;
    end else if (commit_s) begin
      refill_addr_q <= addr_q;
      ppn_q         <= bus.io_ptw_resp_bits_pte_ppn;
      flags_q       <= pte_flags_s;
      fault_q       <= pte_fault(prv_q, pum_q, mxr_q, store_q, fetch_q, pte_flags_s);
    end
  end

  // Wrapping count of completed refills.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   count_q <= '0;
    else if (state_q == S_REFILL) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.miss_ready            = (state_q == S_IDLE);
  assign bus.io_ptw_req_valid      = (state_q == S_REQ);
  assign bus.io_ptw_req_bits_addr  = addr_q;
  assign bus.io_ptw_req_bits_prv   = prv_q;
  assign bus.io_ptw_req_bits_pum   = pum_q;
  assign bus.io_ptw_req_bits_mxr   = mxr_q;
  assign bus.io_ptw_req_bits_store = store_q;
  assign bus.io_ptw_req_bits_fetch = fetch_q;
  assign bus.refill_valid          = (state_q == S_REFILL);
  assign bus.refill_addr           = refill_addr_q;
  assign bus.refill_ppn            = ppn_q;
  assign bus.refill_flags          = flags_q;
  assign bus.refill_fault          = fault_q;
  assign bus.walk_count            = count_q;

endmodule

// File: tb/tb_tlb_ptw_requestor.sv
// Scoreboard bench for tlb_ptw_requestor: directed walks push expected refills,
// a negedge monitor pops and compares every refill pulse.
module tb_tlb_ptw_requestor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tlb_ptw_requestor_if #(.CNT_W(16)) bus ();
  tlb_ptw_requestor_if #(.CNT_W(4))  bus2 ();

  tlb_ptw_requestor #(.CNT_W(16)) dut  (.clock(clock), .reset(reset), .bus(bus));
  tlb_ptw_requestor #(.CNT_W(4))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic [26:0] addr;
    logic [37:0] ppn;
    logic [7:0]  flags;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  int   n2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every refill pulse must match the oldest expected refill.
  always @(negedge clock) begin
    if (bus.refill_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_refill", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("refill_addr",  64'(bus.refill_addr),  64'(e.addr));
        chk("refill_ppn",   64'(bus.refill_ppn),   64'(e.ppn));
        chk("refill_flags", 64'(bus.refill_flags), 64'(e.flags));
        chk("refill_fault", 64'(bus.refill_fault), 64'(e.fault));
      end
    end
  end

  task automatic set_pte(input logic [37:0] ppn, input logic [7:0] fl);
    bus.io_ptw_resp_bits_pte_ppn = ppn;
    bus.io_ptw_resp_bits_pte_reserved_for_hardware = 16'hA5A5;
    bus.io_ptw_resp_bits_pte_reserved_for_software = 2'b10;
    {bus.io_ptw_resp_bits_pte_d, bus.io_ptw_resp_bits_pte_a, bus.io_ptw_resp_bits_pte_g,
     bus.io_ptw_resp_bits_pte_u, bus.io_ptw_resp_bits_pte_x, bus.io_ptw_resp_bits_pte_w,
     bus.io_ptw_resp_bits_pte_r, bus.io_ptw_resp_bits_pte_v} = fl;
  endtask

  // Present a miss and let it be accepted; afterwards the DUT is in REQ.
  task automatic to_req(input logic [26:0] a, input logic [1:0] p, input logic pum,
                        input logic mxr, input logic st, input logic fe);
    bus.miss_addr = a; bus.miss_prv = p; bus.miss_pum = pum;
    bus.miss_mxr = mxr; bus.miss_store = st; bus.miss_fetch = fe;
    bus.miss_valid = 1'b1;
    chk("miss_ready_idle", 64'(bus.miss_ready), 64'd1);
    step();
    bus.miss_valid = 1'b0;
    // Scramble the miss inputs: request bits must come from latched state.
    bus.miss_addr = ~a; bus.miss_prv = ~p; bus.miss_pum = ~pum;
    bus.miss_mxr = ~mxr; bus.miss_store = ~st; bus.miss_fetch = ~fe;
  endtask

  task automatic walk(input logic [26:0] a, input logic [1:0] p, input logic pum, input logic mxr,
                      input logic st, input logic fe, input logic [37:0] ppn, input logic [7:0] fl,
                      input int rdly, input int wdly, input logic ef);
    logic [32:0] bits_exp;
    bits_exp = {p, pum, mxr, st, fe, a};
    to_req(a, p, pum, mxr, st, fe);
    for (int i = 0; i < rdly; i++) begin
      bus.io_ptw_req_ready = 1'b0;
      chk("req_valid_bp", 64'(bus.io_ptw_req_valid), 64'd1);
      chk("req_bits_bp", 64'({bus.io_ptw_req_bits_prv, bus.io_ptw_req_bits_pum, bus.io_ptw_req_bits_mxr,
          bus.io_ptw_req_bits_store, bus.io_ptw_req_bits_fetch, bus.io_ptw_req_bits_addr}), 64'(bits_exp));
      chk("miss_ready_bp", 64'(bus.miss_ready), 64'd0);
      step();
    end
    bus.io_ptw_req_ready = 1'b1;
    chk("req_valid", 64'(bus.io_ptw_req_valid), 64'd1);
    chk("req_bits", 64'({bus.io_ptw_req_bits_prv, bus.io_ptw_req_bits_pum, bus.io_ptw_req_bits_mxr,
        bus.io_ptw_req_bits_store, bus.io_ptw_req_bits_fetch, bus.io_ptw_req_bits_addr}), 64'(bits_exp));
    step();
    bus.io_ptw_req_ready = 1'b0;
    for (int i = 0; i < wdly; i++) begin
      chk("req_valid_wait", 64'(bus.io_ptw_req_valid), 64'd0);
      chk("miss_ready_wait", 64'(bus.miss_ready), 64'd0);
      step();
    end
    set_pte(ppn, fl);
    bus.io_ptw_resp_valid = 1'b1;
    q.push_back('{addr: a, ppn: ppn, flags: fl, fault: ef});
    exp_cnt++;
    step();
    bus.io_ptw_resp_valid = 1'b0;
    chk("refill_latency", 64'(bus.refill_valid), 64'd1);
    chk("miss_ready_refill", 64'(bus.miss_ready), 64'd0);
    step();
    chk("refill_one_cycle", 64'(bus.refill_valid), 64'd0);
    chk("walk_count", 64'(bus.walk_count), 64'(exp_cnt));
    chk("miss_ready_back", 64'(bus.miss_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"},    64'(bus.io_ptw_req_valid), 64'd0);
    chk({tag, "_refill_valid"}, 64'(bus.refill_valid),     64'd0);
    chk({tag, "_refill_fault"}, 64'(bus.refill_fault),     64'd0);
    chk({tag, "_walk_count"},   64'(bus.walk_count),       64'd0);
    chk({tag, "_refill_ppn"},   64'(bus.refill_ppn),       64'd0);
    chk({tag, "_req_addr"},     64'(bus.io_ptw_req_bits_addr), 64'd0);
    chk({tag, "_miss_ready"},   64'(bus.miss_ready),       64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.miss_valid = 1'b0; bus.miss_addr = 27'd0; bus.miss_prv = 2'd0;
    bus.miss_pum = 1'b0; bus.miss_mxr = 1'b0; bus.miss_store = 1'b0; bus.miss_fetch = 1'b0;
    bus.flush = 1'b0; bus.io_ptw_req_ready = 1'b0; bus.io_ptw_resp_valid = 1'b0;
    set_pte(38'd0, 8'd0);
    bus2.miss_valid = 1'b0; bus2.miss_addr = 27'h0000123; bus2.miss_prv = 2'd3;
    bus2.miss_pum = 1'b0; bus2.miss_mxr = 1'b0; bus2.miss_store = 1'b0; bus2.miss_fetch = 1'b0;
    bus2.flush = 1'b0; bus2.io_ptw_req_ready = 1'b1; bus2.io_ptw_resp_valid = 1'b1;
    bus2.io_ptw_resp_bits_pte_ppn = 38'd7;
    bus2.io_ptw_resp_bits_pte_reserved_for_hardware = 16'd0;
    bus2.io_ptw_resp_bits_pte_reserved_for_software = 2'd0;
    {bus2.io_ptw_resp_bits_pte_d, bus2.io_ptw_resp_bits_pte_a, bus2.io_ptw_resp_bits_pte_g,
     bus2.io_ptw_resp_bits_pte_u, bus2.io_ptw_resp_bits_pte_x, bus2.io_ptw_resp_bits_pte_w,
     bus2.io_ptw_resp_bits_pte_r, bus2.io_ptw_resp_bits_pte_v} = 8'h43;

    step(); step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Directed walks: addr, prv, pum, mxr, store, fetch, ppn, flags, ready delay, resp delay, fault
    walk(27'h1234567, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 38'h00ABCDEF,  8'h43, 0, 0, 1'b0); // basic load
    walk(27'h7654321, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 38'h3FFFFFFFFF, 8'hC7, 5, 2, 1'b0); // backpressure
    walk(27'h0000001, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 38'h0000000111, 8'h47, 1, 0, 1'b1); // store w=1 d=0
    walk(27'h2AAAAAA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 38'h2222222222, 8'h59, 0, 1, 1'b0); // U fetch x,u
    walk(27'h5555555, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 38'h0000033333, 8'h53, 2, 0, 1'b1); // S pum on u page
    walk(27'h7FFFFFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 38'h0000044444, 8'h02, 0, 3, 1'b1); // v=0
    walk(27'h0F0F0F0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 38'h0000055555, 8'h49, 0, 0, 1'b0); // mxr on x-only

    // Flush in WAIT, response three cycles later, flush held once in DRAIN.
    to_req(27'h0111111, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.io_ptw_req_ready = 1'b1; step(); bus.io_ptw_req_ready = 1'b0;
    bus.flush = 1'b1; step();
    chk("drain_busy", 64'(bus.miss_ready), 64'd0);
    step(); bus.flush = 1'b0;
    chk("drain_flush_stays", 64'(bus.miss_ready), 64'd0);
    step();
    set_pte(38'h0000099999, 8'h43);
    bus.io_ptw_resp_valid = 1'b1; step(); bus.io_ptw_resp_valid = 1'b0;
    chk("drain_no_refill", 64'(bus.refill_valid), 64'd0);
    chk("drain_idle", 64'(bus.miss_ready), 64'd1);
    chk("drain_count", 64'(bus.walk_count), 64'(exp_cnt));

    // Flush together with the handshake goes to DRAIN.
    to_req(27'h0222222, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.io_ptw_req_ready = 1'b1; bus.flush = 1'b1; step();
    bus.io_ptw_req_ready = 1'b0; bus.flush = 1'b0;
    chk("hs_flush_req_valid", 64'(bus.io_ptw_req_valid), 64'd0);
    chk("hs_flush_drain", 64'(bus.miss_ready), 64'd0);
    bus.io_ptw_resp_valid = 1'b1; step(); bus.io_ptw_resp_valid = 1'b0;
    chk("hs_flush_idle", 64'(bus.miss_ready), 64'd1);

    // Flush in REQ without ready drops the request.
    to_req(27'h0333333, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk("req_flush_valid", 64'(bus.io_ptw_req_valid), 64'd0);
    chk("req_flush_idle", 64'(bus.miss_ready), 64'd1);

    // Flush in WAIT together with the response discards it.
    to_req(27'h0444444, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.io_ptw_req_ready = 1'b1; step(); bus.io_ptw_req_ready = 1'b0;
    bus.io_ptw_resp_valid = 1'b1; bus.flush = 1'b1; step();
    bus.io_ptw_resp_valid = 1'b0; bus.flush = 1'b0;
    chk("wait_flush_idle", 64'(bus.miss_ready), 64'd1);
    chk("wait_flush_no_refill", 64'(bus.refill_valid), 64'd0);
    chk("wait_flush_ppn_held", 64'(bus.refill_ppn), 64'h0000055555);

    // Spurious response in IDLE is ignored.
    bus.io_ptw_resp_valid = 1'b1; step(); bus.io_ptw_resp_valid = 1'b0;
    chk("spurious_idle", 64'(bus.miss_ready), 64'd1);
    chk("spurious_no_refill", 64'(bus.refill_valid), 64'd0);
    chk("spurious_count", 64'(bus.walk_count), 64'(exp_cnt));

    // Counter wrap on a 4-bit instance: 16 refills bring walk_count back to 0.
    chk("wrap_start", 64'(bus2.walk_count), 64'd0);
    bus2.miss_valid = 1'b1;
    for (int i = 0; i < 200 && n2 < 16; i++) begin
      @(negedge clock);
      if (bus2.refill_valid === 1'b1) n2++;
    end
    chk("wrap_refills", 64'(n2), 64'd16);
    step();
    chk("wrap_count", 64'(bus2.walk_count), 64'd0);
    bus2.miss_valid = 1'b0;

    // Reset during WAIT abandons the walk.
    to_req(27'h0555555, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.io_ptw_req_ready = 1'b1; step(); bus.io_ptw_req_ready = 1'b0;
    reset = 1'b1; #2;
    chk_reset_outputs("midreset");
    bus.io_ptw_resp_valid = 1'b1; step(); bus.io_ptw_resp_valid = 1'b0;
    reset = 1'b0; exp_cnt = 0;
    step();
    chk("post_reset_no_refill", 64'(bus.refill_valid), 64'd0);
    chk("post_reset_count", 64'(bus.walk_count), 64'd0);
    walk(27'h1234567, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 38'h0000000ABC, 8'h43, 0, 0, 1'b1); // U load, u=0
    step();

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
